// File: rtl/rlwe_vec_lsu_if.sv
// Interfaces for the RLWE vector LSU.
// EXU command/response side and the beat-wide data-memory side.

interface rlwe_vec_lsu_exu_if #(
    parameter int LANES  = 16,
    parameter int ELEM_W = 32,
    parameter int AW     = 32
);
    logic                      exu2lsu_req;
    logic [2:0]                exu2lsu_cmd;
    logic [AW-1:0]             exu2lsu_addr;
    logic [LANES*ELEM_W-1:0]   exu2lsu_s_data;
    logic                      lsu2exu_rdy;
    logic [LANES*ELEM_W-1:0]   lsu2exu_l_data;
    logic                      lsu2exu_exc;
    logic [3:0]                lsu2exu_exc_code;
    logic                      lsu_busy;

    modport master (
        output exu2lsu_req, exu2lsu_cmd, exu2lsu_addr, exu2lsu_s_data,
        input  lsu2exu_rdy, lsu2exu_l_data, lsu2exu_exc,
        input  lsu2exu_exc_code, lsu_busy
    );

    modport slave (
        input  exu2lsu_req, exu2lsu_cmd, exu2lsu_addr, exu2lsu_s_data,
        output lsu2exu_rdy, lsu2exu_l_data, lsu2exu_exc,
        output lsu2exu_exc_code, lsu_busy
    );
endinterface

interface rlwe_vec_lsu_dmem_if #(
    parameter int BUS_LANES = 4,
    parameter int ELEM_W    = 32,
    parameter int AW        = 32
);
    logic                          lsu2dmem_req;
    logic                          lsu2dmem_cmd;
    logic                          lsu2dmem_width;
    logic [AW-1:0]                 lsu2dmem_addr;
    logic [BUS_LANES*ELEM_W-1:0]   lsu2dmem_wdata;
    logic                          dmem2lsu_req_ack;
    logic [BUS_LANES*ELEM_W-1:0]   dmem2lsu_rdata;
    logic [1:0]                    dmem2lsu_resp;

    modport master (
        output lsu2dmem_req, lsu2dmem_cmd, lsu2dmem_width,
        output lsu2dmem_addr, lsu2dmem_wdata,
        input  dmem2lsu_req_ack, dmem2lsu_rdata, dmem2lsu_resp
    );

    modport slave (
        input  lsu2dmem_req, lsu2dmem_cmd, lsu2dmem_width,
        input  lsu2dmem_addr, lsu2dmem_wdata,
        output dmem2lsu_req_ack, dmem2lsu_rdata, dmem2lsu_resp
    );
endinterface

// File: rtl/rlwe_vec_lsu.sv
// RLWE vector load/store unit.
// Splits a vector access into bus-wide beats and reassembles loads.

module rlwe_vec_lsu #(
    parameter int LANES     = 16,
    parameter int ELEM_W    = 32,
    parameter int BUS_LANES = 4,
    parameter int AW        = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    rlwe_vec_lsu_exu_if.slave   exu,
    rlwe_vec_lsu_dmem_if.master dmem
);

    localparam int BEATS  = LANES / BUS_LANES;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int VW     = LANES * ELEM_W;
    localparam int BUSW   = BUS_LANES * ELEM_W;
    localparam int BEAT_B = BUSW / 8;
    localparam int VA     = $clog2(VW / 8);

    localparam logic [2:0] C_LW = 3'd1;
    localparam logic [2:0] C_SW = 3'd2;
    localparam logic [2:0] C_LV = 3'd3;
    localparam logic [2:0] C_SV = 3'd4;

    localparam logic [1:0] R_OK  = 2'd1;
    localparam logic [1:0] R_ERR = 2'd2;

    localparam logic [3:0] E_LD_MIS = 4'd4;
    localparam logic [3:0] E_LD_ACC = 4'd5;
    localparam logic [3:0] E_ST_MIS = 4'd6;
    localparam logic [3:0] E_ST_ACC = 4'd7;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              err_q, err_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [VW-1:0]     sdata_q, sdata_d;
    logic [VW-1:0]     ldata_q, ldata_d;

    logic              in_ld, in_st, in_vec, in_valid, in_mis;
    logic              q_ld, q_st, q_vec, q_last;
    logic [BUSW-1:0]   beat_wdata;

    // Decode of the incoming command and its alignment.
    always_comb begin
        in_ld    = (exu.exu2lsu_cmd == C_LW) || (exu.exu2lsu_cmd == C_LV);
        in_st    = (exu.exu2lsu_cmd == C_SW) || (exu.exu2lsu_cmd == C_SV);
        in_vec   = (exu.exu2lsu_cmd == C_LV) || (exu.exu2lsu_cmd == C_SV);
        in_valid = in_ld || in_st;
        if (in_vec) begin
            in_mis = |exu.exu2lsu_addr[VA-1:0];
        end else begin
            in_mis = in_valid && (|exu.exu2lsu_addr[1:0]);
        end
    end

    // Decode of the latched command and the current beat's write lanes.
    always_comb begin
        q_ld   = (cmd_q == C_LW) || (cmd_q == C_LV);
        q_st   = (cmd_q == C_SW) || (cmd_q == C_SV);
        q_vec  = (cmd_q == C_LV) || (cmd_q == C_SV);
        q_last = !q_vec || (beat_q == BW'(BEATS - 1));
        beat_wdata = sdata_q[int'(beat_q)*BUSW +: BUSW];
        if (!q_vec) begin
            beat_wdata = '0;
            beat_wdata[ELEM_W-1:0] = sdata_q[ELEM_W-1:0];
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            err_q   <= 1'b0;
            cmd_q   <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            ldata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            ldata_q <= ldata_d;
        end
    end

    // Next-state logic: accept, issue beats, collect responses.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        err_d   = err_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        ldata_d = ldata_q;
        unique case (state_q)
            IDLE: begin
                if (exu.exu2lsu_req && in_valid && !in_mis) begin
                    cmd_d   = exu.exu2lsu_cmd;
                    addr_d  = exu.exu2lsu_addr;
                    sdata_d = exu.exu2lsu_s_data;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dmem.dmem2lsu_req_ack) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dmem.dmem2lsu_resp == R_OK) begin
                    if (q_ld && q_vec) begin
                        ldata_d[int'(beat_q)*BUSW +: BUSW] = dmem.dmem2lsu_rdata;
                    end else if (q_ld) begin
                        ldata_d = '0;
                        ldata_d[ELEM_W-1:0] = dmem.dmem2lsu_rdata[ELEM_W-1:0];
                    end
                    if (q_last) begin
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + BW'(1);
                        state_d = REQ;
                    end
                end else if (dmem.dmem2lsu_resp == R_ERR) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode for both the EXU and the memory side.
    always_comb begin
        exu.lsu2exu_rdy      = 1'b0;
        exu.lsu2exu_exc      = 1'b0;
        exu.lsu2exu_exc_code = '0;
        dmem.lsu2dmem_req    = 1'b0;
        dmem.lsu2dmem_cmd    = 1'b0;
        dmem.lsu2dmem_width  = 1'b0;
        dmem.lsu2dmem_addr   = '0;
        dmem.lsu2dmem_wdata  = '0;
        unique case (state_q)
            IDLE: begin
                if (exu.exu2lsu_req && (!in_valid || in_mis)) begin
                    exu.lsu2exu_rdy = 1'b1;
                    exu.lsu2exu_exc = in_mis;
                    if (in_mis) begin
                        exu.lsu2exu_exc_code = in_ld ? E_LD_MIS : E_ST_MIS;
                    end
                end
            end
            REQ: begin
                dmem.lsu2dmem_req   = 1'b1;
                dmem.lsu2dmem_cmd   = q_st;
                dmem.lsu2dmem_width = q_vec;
                dmem.lsu2dmem_addr  = addr_q + (AW'(beat_q) * AW'(BEAT_B));
                dmem.lsu2dmem_wdata = beat_wdata;
            end
            DONE: begin
                exu.lsu2exu_rdy = 1'b1;
                exu.lsu2exu_exc = err_q;
                if (err_q) begin
                    exu.lsu2exu_exc_code = q_ld ? E_LD_ACC : E_ST_ACC;
                end
            end
            default: begin
            end
        endcase
    end

    assign exu.lsu2exu_l_data = ldata_q;
    assign exu.lsu_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rlwe_vec_lsu.sv
// Bench for rlwe_vec_lsu: scoreboarded EXU responses and memory beats.
// A reference model predicts beats, exceptions and load data.

module tb_rlwe_vec_lsu;

    localparam int LANES = 16;
    localparam int EW    = 32;
    localparam int BL    = 4;
    localparam int AW    = 32;
    localparam int NB    = LANES / BL;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rlwe_vec_lsu_exu_if  #(.LANES(LANES), .ELEM_W(EW), .AW(AW)) exu ();
    rlwe_vec_lsu_dmem_if #(.BUS_LANES(BL), .ELEM_W(EW), .AW(AW)) dmem ();

    rlwe_vec_lsu #(
        .LANES(LANES), .ELEM_W(EW), .BUS_LANES(BL), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .exu(exu), .dmem(dmem)
    );

    typedef struct {
        logic         exc;
        logic [3:0]   code;
        logic [511:0] ld;
        logic         busy;
    } rsp_t;

    typedef struct {
        logic [31:0]  addr;
        logic         cmd;
        logic         width;
        logic [127:0] wdata;
    } beat_t;

    rsp_t  rsp_q[$];
    beat_t bq[$];

    logic [31:0] env_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    logic [511:0] ref_ld = '0;

    int checks = 0;
    int errors = 0;

    int cfg_err_beat = -1;
    int cfg_ack_beat = -1;
    int cfg_ack_dly  = 0;
    bit cfg_rand     = 0;
    bit cfg_hang     = 0;
    bit cfg_stray    = 0;
    int beat_idx     = 0;

    task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] env_rd(logic [31:0] a);
        logic [31:0] w = a & ~32'd3;
        return env_mem.exists(w) ? env_mem[w] : (w >> 2);
    endfunction

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        logic [31:0] w = a & ~32'd3;
        return ref_mem.exists(w) ? ref_mem[w] : (w >> 2);
    endfunction

    // Memory responder: acks beats, checks them, returns data.
    initial begin
        bit           pend = 0, stall = 0, p_err = 0, p_hang = 0;
        bit           p_wr = 0, p_wide = 0;
        int           ack_left = 0, rdly = 0;
        logic [31:0]  p_addr = 0;
        logic [127:0] p_rdata = 0, p_wdata = 0;
        logic [162:0] snap = 0, cur;
        dmem.dmem2lsu_req_ack = 1'b0;
        dmem.dmem2lsu_resp    = 2'd0;
        dmem.dmem2lsu_rdata   = '0;
        forever begin
            @(negedge clk);
            dmem.dmem2lsu_req_ack = 1'b0;
            dmem.dmem2lsu_resp    = 2'd0;
            if (!rst_n) begin
                pend = 0;
                stall = 0;
                continue;
            end
            if (cfg_stray) begin
                dmem.dmem2lsu_resp = 2'd1;
                cfg_stray = 0;
                continue;
            end
            cur = {dmem.lsu2dmem_addr, dmem.lsu2dmem_cmd,
                   dmem.lsu2dmem_width, dmem.lsu2dmem_wdata};
            if (pend) begin
                if (rdly > 0) begin
                    rdly--;
                end else if (!p_hang) begin
                    dmem.dmem2lsu_resp  = p_err ? 2'd2 : 2'd1;
                    dmem.dmem2lsu_rdata = p_rdata;
                    pend = 0;
                    if (!p_err && p_wr) begin
                        for (int j = 0; j < BL; j++) begin
                            if (p_wide || j == 0)
                                env_mem[(p_addr + 32'(4*j)) & ~32'd3] =
                                    p_wdata[j*32 +: 32];
                        end
                    end
                end
            end else if (dmem.lsu2dmem_req) begin
                if (!stall) begin
                    stall = 1;
                    snap = cur;
                    if (beat_idx == cfg_ack_beat) ack_left = cfg_ack_dly;
                    else if (cfg_rand) ack_left = $urandom_range(0, 2);
                    else ack_left = 0;
                end else begin
                    chk("req_stable", {349'd0, cur}, {349'd0, snap});
                end
                if (ack_left == 0) begin
                    beat_t e;
                    dmem.dmem2lsu_req_ack = 1'b1;
                    stall = 0;
                    if (bq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat addr=%0h",
                                 dmem.lsu2dmem_addr);
                    end else begin
                        e = bq.pop_front();
                        chk("beat_addr", {480'd0, dmem.lsu2dmem_addr},
                            {480'd0, e.addr});
                        chk("beat_cmd_width",
                            {510'd0, dmem.lsu2dmem_cmd, dmem.lsu2dmem_width},
                            {510'd0, e.cmd, e.width});
                        if (e.cmd)
                            chk("beat_wdata", {384'd0, dmem.lsu2dmem_wdata},
                                {384'd0, e.wdata});
                    end
                    p_addr  = dmem.lsu2dmem_addr;
                    p_wr    = dmem.lsu2dmem_cmd;
                    p_wide  = dmem.lsu2dmem_width;
                    p_wdata = dmem.lsu2dmem_wdata;
                    for (int j = 0; j < BL; j++) begin
                        if (p_wide || j == 0)
                            p_rdata[j*32 +: 32] = env_rd(p_addr + 32'(4*j));
                        else
                            p_rdata[j*32 +: 32] = $urandom;
                    end
                    p_err  = (beat_idx == cfg_err_beat);
                    p_hang = cfg_hang && (beat_idx == 2);
                    rdly   = cfg_rand ? $urandom_range(0, 2) : 0;
                    beat_idx++;
                    pend = 1;
                end else begin
                    ack_left--;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every rdy.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && exu.lsu2exu_rdy) begin
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rdy exc=%0b",
                             exu.lsu2exu_exc);
                end else begin
                    e = rsp_q.pop_front();
                    chk("exc", {511'd0, exu.lsu2exu_exc}, {511'd0, e.exc});
                    if (e.exc)
                        chk("exc_code", {508'd0, exu.lsu2exu_exc_code},
                            {508'd0, e.code});
                    chk("l_data", exu.lsu2exu_l_data, e.ld);
                    chk("busy_at_rdy", {511'd0, exu.lsu_busy},
                        {511'd0, e.busy});
                end
            end
        end
    end

    task automatic do_op(input logic [2:0] cmd, input logic [31:0] addr,
                         input logic [511:0] sd, input int err_beat,
                         input int lat);
        bit   ld, st, vec, mis;
        int   nb, last, n;
        rsp_t r;
        ld  = (cmd == 3'd1) || (cmd == 3'd3);
        st  = (cmd == 3'd2) || (cmd == 3'd4);
        vec = (cmd == 3'd3) || (cmd == 3'd4);
        mis = vec ? (addr % 64 != 0) : ((ld || st) && addr % 4 != 0);
        r.exc = 0; r.code = 0; r.busy = 0;
        if (ld || st) begin
            if (mis) begin
                r.exc  = 1;
                r.code = ld ? 4'd4 : 4'd6;
            end else begin
                nb   = vec ? NB : 1;
                last = (err_beat >= 0 && err_beat < nb) ? err_beat : nb - 1;
                r.busy = 1;
                for (int b = 0; b <= last; b++) begin
                    beat_t e;
                    e.addr  = addr + 32'(b * 16);
                    e.cmd   = st;
                    e.width = vec;
                    e.wdata = vec ? sd[b*128 +: 128] : {96'd0, sd[31:0]};
                    bq.push_back(e);
                    if (b == err_beat) begin
                        r.exc  = 1;
                        r.code = ld ? 4'd5 : 4'd7;
                    end else if (ld && vec) begin
                        for (int j = 0; j < BL; j++)
                            ref_ld[(b*BL+j)*32 +: 32] =
                                ref_rd(e.addr + 32'(4*j));
                    end else if (ld) begin
                        ref_ld = {480'd0, ref_rd(addr)};
                    end else begin
                        for (int j = 0; j < (vec ? BL : 1); j++)
                            ref_mem[(e.addr + 32'(4*j)) & ~32'd3] =
                                e.wdata[j*32 +: 32];
                    end
                end
            end
        end
        r.ld = ref_ld;
        rsp_q.push_back(r);
        beat_idx = 0;
        cfg_err_beat = err_beat;
        @(posedge clk);
        #1;
        exu.exu2lsu_req    = 1'b1;
        exu.exu2lsu_cmd    = cmd;
        exu.exu2lsu_addr   = addr;
        exu.exu2lsu_s_data = sd;
        n = 0;
        forever begin
            @(negedge clk);
            if (exu.lsu2exu_rdy) break;
            n++;
            if (n > 300) begin
                errors++;
                $display("FAIL rdy_timeout cmd=%0d addr=%0h", cmd, addr);
                rsp_q.delete();
                bq.delete();
                break;
            end
        end
        if (lat >= 0) chk("latency", 512'(n), 512'(lat));
        #1;
        exu.exu2lsu_req = 1'b0;
        exu.exu2lsu_cmd = 3'd0;
        @(negedge clk);
        chk("rdy_single_pulse", {511'd0, exu.lsu2exu_rdy}, 512'd0);
        if (bq.size() != 0) begin
            errors++;
            $display("FAIL beats_missing left=%0d", bq.size());
            bq.delete();
        end
    endtask

    function automatic logic [511:0] rand_vec();
        logic [511:0] v;
        for (int i = 0; i < LANES; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] v;
        int           n;
        exu.exu2lsu_req    = 1'b0;
        exu.exu2lsu_cmd    = 3'd0;
        exu.exu2lsu_addr   = '0;
        exu.exu2lsu_s_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {exu.lsu2exu_l_data[479:0], exu.lsu2exu_rdy, exu.lsu2exu_exc,
             exu.lsu2exu_exc_code, exu.lsu_busy, dmem.lsu2dmem_req,
             dmem.lsu2dmem_cmd, dmem.lsu2dmem_width, 23'd0},
            512'd0);
        #1 rst_n = 1'b1;

        do_op(3'd3, 32'h100, '0, -1, 9);
        for (int i = 0; i < LANES; i++) v[i*32 +: 32] = i;
        cfg_ack_beat = 2; cfg_ack_dly = 3;
        do_op(3'd4, 32'h200, v, -1, 12);
        cfg_ack_beat = -1; cfg_ack_dly = 0;
        do_op(3'd3, 32'h200, '0, -1, 9);
        do_op(3'd3, 32'h100, '0, -1, 9);
        do_op(3'd3, 32'h180, '0, 1, 5);
        do_op(3'd4, 32'h104, v, -1, 0);
        do_op(3'd1, 32'h102, '0, -1, 0);
        env_mem[32'h40] = 32'hDEADBEEF;
        ref_mem[32'h40] = 32'hDEADBEEF;
        do_op(3'd1, 32'h40, '0, -1, 3);
        do_op(3'd2, 32'h44, rand_vec(), -1, 3);
        do_op(3'd1, 32'h44, '0, -1, 3);
        do_op(3'd4, 32'h280, rand_vec(), 2, 7);
        do_op(3'd3, 32'h280, '0, -1, 9);
        do_op(3'd0, 32'h300, '0, -1, 0);
        do_op(3'd6, 32'h301, '0, -1, 0);

        // Reset while beat 2 of a load is outstanding.
        bq.push_back('{32'h300, 1'b0, 1'b1, 128'd0});
        bq.push_back('{32'h310, 1'b0, 1'b1, 128'd0});
        bq.push_back('{32'h320, 1'b0, 1'b1, 128'd0});
        beat_idx = 0;
        cfg_err_beat = -1;
        cfg_hang = 1;
        @(posedge clk);
        #1;
        exu.exu2lsu_req  = 1'b1;
        exu.exu2lsu_cmd  = 3'd3;
        exu.exu2lsu_addr = 32'h300;
        n = 0;
        while (beat_idx < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_beat2", 512'(beat_idx), 512'd3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        exu.exu2lsu_req = 1'b0;
        exu.exu2lsu_cmd = 3'd0;
        @(negedge clk);
        chk("midop_reset_outputs",
            {exu.lsu2exu_l_data[479:0], exu.lsu2exu_rdy, exu.lsu2exu_exc,
             exu.lsu2exu_exc_code, exu.lsu_busy, dmem.lsu2dmem_req,
             dmem.lsu2dmem_cmd, dmem.lsu2dmem_width, 23'd0},
            512'd0);
        chk("midop_beats_consumed", 512'(bq.size()), 512'd0);
        bq.delete();
        ref_ld = '0;
        cfg_hang = 0;
        #1 rst_n = 1'b1;
        cfg_stray = 1;
        repeat (3) @(negedge clk);
        chk("after_stray",
            {508'd0, exu.lsu_busy, dmem.lsu2dmem_req, exu.lsu2exu_rdy,
             exu.lsu2exu_exc},
            512'd0);
        do_op(3'd1, 32'h40, '0, -1, 3);

        cfg_rand = 1;
        for (int t = 0; t < 40; t++) begin
            logic [2:0]  c;
            logic [31:0] a;
            int          eb;
            c = 3'($urandom_range(0, 9));
            if (c > 3'd4 && $urandom_range(0, 3) != 0) c = 3'($urandom_range(1, 4));
            if (c == 3'd3 || c == 3'd4) a = 32'($urandom_range(0, 15) * 64);
            else a = 32'($urandom_range(0, 255) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            eb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, NB - 1) : -1;
            do_op(c, a, rand_vec(), eb, -1);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
